// File: rtl/cpu_isa_pkg.sv
// ISA constants, FSM encoding and control bundle shared by the
// 16-bit CPU control unit and its instruction decoder.
package cpu_isa_pkg;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int DA_MSB  = 11;
   localparam int DA_LSB  = 8;
   localparam int AA_MSB  = 7;
   localparam int AA_LSB  = 4;
   localparam int BA_MSB  = 3;
   localparam int BA_LSB  = 0;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   localparam logic [3:0] OP_LDI  = 4'h8;
   localparam logic [3:0] OP_LD   = 4'h9;
   localparam logic [3:0] OP_ST   = 4'hA;
   localparam logic [3:0] OP_BZ   = 4'hB;
   localparam logic [3:0] OP_BNZ  = 4'hC;
   localparam logic [3:0] OP_JMP  = 4'hD;
   localparam logic [3:0] OP_JAL  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [1:0] SOURCE_F         = 2'd0;
   localparam logic [1:0] SOURCE_PC        = 2'd1;
   localparam logic [1:0] SOURCE_RAM       = 2'd2;
   localparam logic [1:0] SOURCE_IMMEDIATE = 2'd3;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_HALTED
   } state_t;

   typedef enum logic [1:0] {
      NS_FETCH,
      NS_MEM,
      NS_HALT
   } next_class_t;

   typedef struct packed {
      logic [2:0] fs;
      logic       mb;
      logic [1:0] rsrc;
      logic       rw;
      logic       mw;
      logic       br_zero;
      logic       br_nonzero;
      logic       jump;
   } ctrl_t;

   function automatic logic is_alu(input logic [3:0] op);
      return !op[3];
   endfunction

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational control decode from the FSM state and the
// opcode held in the instruction register.
module cpu_instr_decode
   import cpu_isa_pkg::*;
(
   input  state_t      state,
   input  logic [3:0]  op,
   output ctrl_t       ctrl,
   output next_class_t next_class
);

   always_comb begin
      ctrl       = '0;
      next_class = NS_FETCH;
      unique case (state)
         S_EXECUTE: begin
            unique case (1'b1)
               is_alu(op): begin
                  ctrl.fs   = op[2:0];
                  ctrl.rsrc = SOURCE_F;
                  ctrl.rw   = 1'b1;
               end
               (op == OP_LDI): begin
                  ctrl.rsrc = SOURCE_IMMEDIATE;
                  ctrl.rw   = 1'b1;
               end
               (op == OP_LD): begin
                  ctrl.rsrc  = SOURCE_RAM;
                  next_class = NS_MEM;
               end
               (op == OP_ST):
                  ctrl.mw = 1'b1;
               (op == OP_BZ):
                  ctrl.br_zero = 1'b1;
               (op == OP_BNZ):
                  ctrl.br_nonzero = 1'b1;
               (op == OP_JMP):
                  ctrl.jump = 1'b1;
               (op == OP_JAL): begin
                  ctrl.jump = 1'b1;
                  ctrl.rsrc = SOURCE_PC;
                  ctrl.rw   = 1'b1;
               end
               (op == OP_HALT):
                  next_class = NS_HALT;
               default: ;
            endcase
         end
         S_MEM: begin
            ctrl.rsrc = SOURCE_RAM;
            ctrl.rw   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit: owns PC, IR and the
// fetch/decode/execute/mem FSM for the 16-bit datapath.
module cpu_control_unit
   import cpu_isa_pkg::*;
#(
   parameter int INSTR_WIDTH = 16,
   parameter int PC_WIDTH    = 16,
   parameter int BUS_SIZE    = 16,
   parameter int ADDR_WIDTH  = 4,
   parameter int FS_WIDTH    = 3,
   parameter int RSRC_WIDTH  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   instr_req,
   input  logic                   instr_ack,
   input  logic [INSTR_WIDTH-1:0] instr_data,
   output logic [PC_WIDTH-1:0]    pc,
   input  logic [BUS_SIZE-1:0]    Dout,
   input  logic [BUS_SIZE-1:0]    Aout,
   output logic [ADDR_WIDTH-1:0]  DA,
   output logic [ADDR_WIDTH-1:0]  AA,
   output logic [ADDR_WIDTH-1:0]  BA,
   output logic [FS_WIDTH-1:0]    FS,
   output logic                   MB,
   output logic [RSRC_WIDTH-1:0]  resultSource,
   output logic                   RW,
   output logic                   MW,
   output logic                   halted
);

   state_t                 state;
   logic [INSTR_WIDTH-1:0] ir;
   ctrl_t                  ctrl;
   next_class_t            next_class;
   logic [3:0]             op;
   logic [7:0]             imm;
   logic [PC_WIDTH-1:0]    br_off;
   logic [PC_WIDTH-1:0]    jmp_tgt;
   logic                   dout_zero;
   logic                   taken;

   assign op  = ir[OP_MSB:OP_LSB];
   assign imm = ir[IMM_MSB:IMM_LSB];

   cpu_instr_decode u_dec (
      .state      (state),
      .op         (op),
      .ctrl       (ctrl),
      .next_class (next_class)
   );

   assign DA = ir[DA_MSB:DA_LSB];
   assign AA = ir[AA_MSB:AA_LSB];
   assign BA = ir[BA_MSB:BA_LSB];

   assign FS           = FS_WIDTH'(ctrl.fs);
   assign MB           = ctrl.mb;
   assign resultSource = RSRC_WIDTH'(ctrl.rsrc);

   // Writes are suppressed in the reset cycle itself.
   assign RW = ctrl.rw & ~reset;
   assign MW = ctrl.mw & ~reset;

   assign br_off    = {{(PC_WIDTH-8){imm[7]}}, imm};
   assign jmp_tgt   = PC_WIDTH'(Aout);
   assign dout_zero = (Dout == '0);
   assign taken     = (ctrl.br_zero & dout_zero)
                    | (ctrl.br_nonzero & ~dout_zero);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FETCH;
         pc        <= '0;
         ir        <= '0;
         instr_req <= 1'b1;
         halted    <= 1'b0;
      end else begin
         unique case (state)
            S_FETCH: begin
               if (instr_ack) begin
                  ir        <= instr_data;
                  instr_req <= 1'b0;
                  state     <= S_DECODE;
               end
            end
            S_DECODE: begin
               pc    <= pc + PC_WIDTH'(1);
               state <= S_EXECUTE;
            end
            S_EXECUTE: begin
               // pc already points past the branch here
               if (taken)
                  pc <= pc + br_off;
               else if (ctrl.jump)
                  pc <= jmp_tgt;
               unique case (next_class)
                  NS_MEM:
                     state <= S_MEM;
                  NS_HALT: begin
                     state  <= S_HALTED;
                     halted <= 1'b1;
                  end
                  default: begin
                     state     <= S_FETCH;
                     instr_req <= 1'b1;
                  end
               endcase
            end
            S_MEM: begin
               state     <= S_FETCH;
               instr_req <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: vector table,
// directed corner sequences and randomized model checks.
module tb_cpu_control_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_req;
   logic        instr_ack = 1'b0;
   logic [15:0] instr_data = '0;
   logic [15:0] pc;
   logic [15:0] Dout = '0;
   logic [15:0] Aout = '0;
   logic [3:0]  DA, AA, BA;
   logic [2:0]  FS;
   logic        MB;
   logic [1:0]  resultSource;
   logic        RW, MW, halted;

   cpu_control_unit dut (
      .clk          (clk),
      .reset        (reset),
      .instr_req    (instr_req),
      .instr_ack    (instr_ack),
      .instr_data   (instr_data),
      .pc           (pc),
      .Dout         (Dout),
      .Aout         (Aout),
      .DA           (DA),
      .AA           (AA),
      .BA           (BA),
      .FS           (FS),
      .MB           (MB),
      .resultSource (resultSource),
      .RW           (RW),
      .MW           (MW),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rw;
      logic        mw;
      logic [1:0]  rsrc;
      logic        chk_fs;
      logic [2:0]  fs;
      logic        ld;
      logic        halt;
      logic [15:0] npc;
   } exp_t;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] dout;
      logic [15:0] aout;
      exp_t        e;
   } vec_t;

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_pc = '0;
   vec_t        tbl[15];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference behaviour straight from the ISA rules.
   function automatic exp_t model(input logic [15:0] pc0,
                                  input logic [15:0] instr,
                                  input logic [15:0] dout,
                                  input logic [15:0] aout);
      exp_t e;
      int   op, seq, off;
      op  = int'(instr[15:12]);
      seq = int'(pc0) + 1;
      off = int'($signed(instr[7:0]));
      e   = '{default: '0};
      e.npc = 16'(seq);
      if (op < 8) begin
         e.rw = 1'b1; e.chk_fs = 1'b1; e.fs = 3'(op);
      end else begin
         case (op)
            8:  begin e.rw = 1'b1; e.rsrc = 2'd3; end
            9:  begin e.ld = 1'b1; e.rsrc = 2'd2; end
            10: e.mw = 1'b1;
            11: if (dout == 0) e.npc = 16'(seq + off);
            12: if (dout != 0) e.npc = 16'(seq + off);
            13: e.npc = aout;
            14: begin e.rw = 1'b1; e.rsrc = 2'd1; e.npc = aout; end
            default: e.halt = 1'b1;
         endcase
      end
      return e;
   endfunction

   function automatic vec_t mk(input logic [15:0] instr, dout, aout,
                               input logic rw, mw, input logic [1:0] rsrc,
                               input logic chk_fs, input logic [2:0] fs,
                               input logic ld, halt,
                               input logic [15:0] npc);
      vec_t v;
      v.instr = instr; v.dout = dout; v.aout = aout;
      v.e.rw = rw; v.e.mw = mw; v.e.rsrc = rsrc;
      v.e.chk_fs = chk_fs; v.e.fs = fs;
      v.e.ld = ld; v.e.halt = halt; v.e.npc = npc;
      return v;
   endfunction

   function automatic vec_t mkm(input logic [15:0] instr, dout, aout);
      vec_t v;
      v.instr = instr; v.dout = dout; v.aout = aout;
      v.e = model(exp_pc, instr, dout, aout);
      return v;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      instr_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_pc", 32'(pc), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_req", 32'(instr_req), 1);
      chk("rst_rw_mw", 32'({RW, MW}), 0);
      exp_pc = '0;
   endtask

   // Called at a negedge with the DUT in FETCH.
   task automatic run(input vec_t v);
      chk("fetch_req", 32'(instr_req), 1);
      chk("fetch_pc", 32'(pc), 32'(exp_pc));
      chk("fetch_rw_mw", 32'({RW, MW}), 0);
      instr_data = v.instr;
      Dout = v.dout;
      Aout = v.aout;
      instr_ack = 1'b1;
      @(negedge clk);
      instr_ack = 1'b0;
      instr_data = 16'($urandom);
      chk("dec_rw_mw", 32'({RW, MW}), 0);
      chk("dec_req", 32'(instr_req), 0);
      chk("dec_fields", 32'({DA, AA, BA}), 32'(v.instr[11:0]));
      chk("dec_pc", 32'(pc), 32'(exp_pc));
      chk("dec_rsrc_fs", 32'({resultSource, FS, MB}), 0);
      @(negedge clk);
      chk("ex_pc", 32'(pc), 32'(16'(exp_pc + 16'd1)));
      chk("ex_rw", 32'(RW), 32'(v.e.rw));
      chk("ex_mw", 32'(MW), 32'(v.e.mw));
      if (v.e.rw || v.e.ld)
         chk("ex_rsrc", 32'(resultSource), 32'(v.e.rsrc));
      if (v.e.chk_fs)
         chk("ex_fs", 32'(FS), 32'(v.e.fs));
      if (v.e.ld) begin
         @(negedge clk);
         chk("mem_rw", 32'(RW), 1);
         chk("mem_mw", 32'(MW), 0);
         chk("mem_rsrc", 32'(resultSource), 2);
      end
      @(negedge clk);
      if (v.e.halt) begin
         chk("halt_flag", 32'(halted), 1);
         chk("halt_req", 32'(instr_req), 0);
      end else begin
         chk("next_req", 32'(instr_req), 1);
         chk("next_halted", 32'(halted), 0);
      end
      chk("next_pc", 32'(pc), 32'(v.e.npc));
      exp_pc = v.e.npc;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(16'h3123, 0, 0, 1, 0, 2'd0, 1, 3'd3, 0, 0, 16'h0001);
      tbl[1]  = mk(16'h8105, 0, 0, 1, 0, 2'd3, 0, 3'd0, 0, 0, 16'h0001);
      tbl[2]  = mk(16'h9230, 0, 0, 0, 0, 2'd2, 0, 3'd0, 1, 0, 16'h0001);
      tbl[3]  = mk(16'hA034, 0, 0, 0, 1, 2'd0, 0, 3'd0, 0, 0, 16'h0001);
      tbl[4]  = mk(16'hB0FE, 0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0, 16'hFFFF);
      tbl[5]  = mk(16'hB0FE, 1, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0, 16'h0001);
      tbl[6]  = mk(16'hC07F, 5, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0, 16'h0080);
      tbl[7]  = mk(16'hC080, 0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0, 16'h0001);
      tbl[8]  = mk(16'hC080, 7, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0, 16'hFF81);
      tbl[9]  = mk(16'hB0FF, 0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0, 16'h0000);
      tbl[10] = mk(16'hD0A0, 0, 16'h1234, 0, 0, 2'd0, 0, 3'd0, 0, 0,
                   16'h1234);
      tbl[11] = mk(16'hE560, 0, 16'hFFFF, 1, 0, 2'd1, 0, 3'd0, 0, 0,
                   16'hFFFF);
      tbl[12] = mk(16'h0777, 0, 0, 1, 0, 2'd0, 1, 3'd0, 0, 0, 16'h0001);
      tbl[13] = mk(16'h7ABC, 0, 0, 1, 0, 2'd0, 1, 3'd7, 0, 0, 16'h0001);
      tbl[14] = mk(16'hF000, 0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 1, 16'h0001);

      do_reset();
      run(mkm(16'h8105, 0, 0));
      run(mkm(16'h9230, 0, 0));
      run(mkm(16'h1123, 0, 0));
      run(mkm(16'h2456, 0, 0));
      run(mkm(16'hB0FE, 16'h0000, 0));
      chk("bz_taken_pc", 32'(pc), 3);
      run(mkm(16'h3000, 0, 0));
      run(mkm(16'hB0FE, 16'h0001, 0));
      chk("bz_not_taken_pc", 32'(pc), 5);
      run(mkm(16'h4000, 0, 0));
      run(mkm(16'h5000, 0, 0));
      run(mkm(16'hE560, 0, 16'h0020));
      chk("jal_target_pc", 32'(pc), 32'h20);
      run(mkm(16'hF000, 0, 0));
      instr_ack = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("halt_pc_frozen", 32'(pc), 32'h21);
         chk("halt_hold", 32'({halted, instr_req, RW, MW}), 32'b1000);
      end
      do_reset();

      instr_data = 16'hA034;
      instr_ack = 1'b1;
      @(negedge clk);
      instr_ack = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      instr_ack = 1'b1;
      #1;
      chk("st_reset_mw", 32'(MW), 0);
      chk("st_reset_rw", 32'(RW), 0);
      @(negedge clk);
      reset = 1'b0;
      instr_ack = 1'b0;
      #1;
      chk("post_reset_pc", 32'(pc), 0);
      chk("post_reset_req", 32'(instr_req), 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_fetch", 32'({instr_req, pc, RW, MW}), 32'h40000);
      end
      exp_pc = '0;
      run(mkm(16'h8105, 0, 0));

      for (int i = 0; i < 15; i++) begin
         do_reset();
         run(tbl[i]);
      end

      do_reset();
      for (int i = 0; i < 300; i++) begin
         logic [15:0] ins, d, a;
         ins = 16'($urandom);
         if (ins[15:12] == 4'hF)
            ins[15:12] = 4'(i % 15);
         d = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
         a = 16'($urandom);
         run(mkm(ins, d, a));
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
